shift_deserializer: RTL and testbench

Sequential serial-to-parallel companion to the ALU shift unit. It receives a word one bit per cycle, in the same bit order that repeated single-bit shifts push out through the carry. It reassembles the word into a register with the same {C,Out} / {Out,C} shift semantics, then presents the word with C/Z/N/P flags on a valid/ready output. It sits on the receive side of the ALU's serial link, between the bit-stream source and the register file write port.

---
 rtl/shift_deserializer.sv | 149 ++++++++++++++
 tb/tb_shift_deserializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-to-parallel shift register: rebuilds a WIDTH-bit word one bit per cycle, presents word + C/Z/N/P on valid/ready.
// Latency: WIDTH+1 cycles from start to out_valid with an unbroken bit stream (WIDTH+2 with SHIFT_DESER_PARITY_EN).
// Backpressure: bit_valid gaps stall collection; the word is held in HOLD until out_ready; start is ignored while busy.
module shift_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] seed,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             P,
    output logic             busy,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
`ifdef SHIFT_DESER_PARITY_EN
        ,
        PARITY  = 2'd3
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            dir_q;
    logic            take;
    logic            last_bit;
    logic            load;
    logic            shift_en;

    assign take     = bit_valid && bit_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign load     = (state == IDLE) && start;
    assign shift_en = (state == COLLECT) && take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (take && last_bit) begin
`ifdef SHIFT_DESER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = HOLD;
`endif
                end
            end
`ifdef SHIFT_DESER_PARITY_EN
            PARITY: begin
                if (take) begin
                    state_nxt = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy      = 1'b0;
            COLLECT: bit_ready = 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
            PARITY:  bit_ready = 1'b1;
`endif
            HOLD:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Out and C keep their last word through IDLE; only start reloads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out   <= '0;
            C     <= 1'b0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (load) begin
            Out   <= seed;
            C     <= 1'b0;
            cnt   <= '0;
            dir_q <= dir;
        end else if (shift_en) begin
            if (dir_q) begin
                {Out, C} <= {bit_in, Out};
            end else begin
                {C, Out} <= {Out, bit_in};
            end
            cnt <= cnt + CW'(1);
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    // The sender's bit makes the total ones count even, so any odd total is an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (load) begin
            par_err <= 1'b0;
        end else if ((state == PARITY) && take) begin
            par_err <= bit_in ^ (^Out);
        end
    end
`else
    assign par_err = 1'b0;
`endif

    assign Z = ~|Out;
    assign N = Out[WIDTH-1];
    assign P = ~^Out;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: arithmetic reference model checked every cycle plus literal spot checks.
module tb_shift_deserializer;

    localparam int W = 16;
`ifdef SHIFT_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Out;
    logic          C, Z, N, P, busy, par_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .seed(seed),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .C(C),
        .Z(Z), .N(N), .P(P), .busy(busy), .par_err(par_err)
    );

    always #5 clk = ~clk;

    // Reference model: remembers seed and the accepted bits, derives {C,Out} arithmetically.
    int           m_phase = 0;
    logic [W-1:0] m_seed = '0;
    logic         m_dir = 1'b0;
    int           m_k = 0;
    logic [31:0]  m_acc = '0;
    logic         m_perr = 1'b0;
    logic [W:0]   co_now;

    function automatic logic [W:0] mdl_co(input logic [W-1:0] s, input logic d,
                                          input int k, input logic [31:0] acc);
        logic [32:0] ext;
        logic [31:0] o;
        logic        c;
        if (!d) begin
            ext = (33'(s) << k) | 33'(acc);
            return ext[W:0];
        end
        o = (32'(s) >> k) | (acc << (W - k));
        c = 1'b0;
        if (k > 0) c = s[k-1];
        return {c, o[W-1:0]};
    endfunction

    assign co_now = mdl_co(m_seed, m_dir, m_k, m_acc);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_seed <= '0; m_dir <= 1'b0; m_k <= 0; m_acc <= '0; m_perr <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1; m_seed <= seed; m_dir <= dir; m_k <= 0; m_acc <= '0; m_perr <= 1'b0;
                end
                1: if (bit_valid) begin
                    m_acc <= m_dir ? (m_acc | (32'(bit_in) << m_k)) : ((m_acc << 1) | 32'(bit_in));
                    m_k <= m_k + 1;
                    if (m_k == W - 1) m_phase <= PAR ? 2 : 3;
                end
                2: if (bit_valid) begin
                    m_perr <= bit_in ^ 1'($countones(co_now[W-1:0]) % 2);
                    m_phase <= 3;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [W+7:0] expv, actv;
        expv = {m_phase == 3, m_phase == 1 || m_phase == 2, m_phase != 0,
                co_now[W-1:0], co_now[W], co_now[W-1:0] == '0, co_now[W-1],
                ($countones(co_now[W-1:0]) % 2) == 0, m_perr};
        actv = {out_valid, bit_ready, busy, Out, C, Z, N, P, par_err};
        checks++;
        if (actv !== expv) begin
            errors++;
            $display("FAIL cycle_model t=%0t: got %h expected %h", $time, actv, expv);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic d, input logic [W-1:0] s);
        start = 1'b1; dir = d; seed = s;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic d, input bit gaps);
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                bit_valid = 1'b0; bit_in = 1'b1;
                tick();
                chk("gap_ready", 32'(bit_ready), 32'd1);
            end
            bit_valid = 1'b1;
            bit_in = d ? w[i] : w[W-1-i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic chk_word(input string nm, input logic [W-1:0] o, input logic c,
                            input logic z, input logic n, input logic p);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_out"}, 32'(Out), 32'(o));
        chk({nm, "_flags"}, {28'd0, C, Z, N, P}, {28'd0, c, z, n, p});
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_out", 32'(Out), 32'h0);
        chk("rst_flags", {27'd0, C, Z, N, P, busy}, {27'd0, 5'b01010});
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 0xA5C3 MSB-first from a zero seed
        do_start(1'b0, 16'h0000);
        chk("start_ready", 32'(bit_ready), 32'd1);
        send_word(16'hA5C3, 1'b0, 1'b0);
        if (!PAR) begin
            chk("t1_latency", 32'(cyc - c0), 32'd17);
            chk_word("t1", 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1);
            handshake();
        end

`ifdef SHIFT_DESER_PARITY_EN
        for (int pb = 1; pb >= 0; pb--) begin
            if (pb == 0) begin
                do_start(1'b0, 16'h0000);
                send_word(16'hA5C3, 1'b0, 1'b0);
            end
            chk("par_wait_valid", 32'(out_valid), 32'd0);
            chk("par_wait_ready", 32'(bit_ready), 32'd1);
            bit_valid = 1'b1; bit_in = 1'(pb);
            tick();
            bit_valid = 1'b0;
            chk("par_latency", 32'(cyc - c0), 32'd18);
            chk_word("par", 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("par_err", 32'(par_err), 32'(pb));
            handshake();
            chk("par_err_keep", 32'(par_err), 32'(pb));
        end
`endif

        // LSB-first; a bit offered alongside start must be dropped
        bit_valid = 1'b1; bit_in = 1'b1;
        do_start(1'b1, 16'h8001);
        send_word(16'h0001, 1'b1, 1'b0);
        if (PAR) begin bit_valid = 1'b1; bit_in = 1'b1; tick(); bit_valid = 1'b0; end
        chk_word("t2", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        handshake();

        // zero word with a gap before every bit
        do_start(1'b0, 16'h0001);
        c0 = cyc;
        send_word(16'h0000, 1'b0, 1'b1);
        if (!PAR) chk("t3_accept_cycles", 32'(cyc - c0), 32'd32);
        if (PAR) begin bit_valid = 1'b1; bit_in = 1'b0; tick(); bit_valid = 1'b0; end
        chk_word("t3", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // held word while start pulses; start in the handshake cycle is also ignored
        handshake();
        do_start(1'b0, 16'h0000);
        send_word(16'h1234, 1'b0, 1'b0);
        if (PAR) begin bit_valid = 1'b1; bit_in = 1'b1; tick(); bit_valid = 1'b0; end
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; dir = 1'b1; seed = 16'hFFFF; bit_valid = 1'b1;
            tick();
            chk_word("t4_hold", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bit_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_out", 32'(Out), 32'h1234);
        do_start(1'b0, 16'h00F0);
        chk("t4_restart", {29'd0, busy, bit_ready, C}, {29'd0, 3'b110});
        chk("t4_restart_out", 32'(Out), 32'h00F0);

        // abort after 7 bits with an asynchronous reset
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1; bit_in = 1'(i % 2);
            tick();
        end
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_async_out", 32'(Out), 32'h0);
        chk("t5_async_ctl", {26'd0, out_valid, bit_ready, busy, C, Z, P}, {26'd0, 6'b000011});
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        do_start(1'b0, 16'hBEEF);
        send_word(16'h3C5A, 1'b0, 1'b0);
        if (PAR) begin bit_valid = 1'b1; bit_in = 1'b0; tick(); bit_valid = 1'b0; end
        chk_word("t5", 16'h3C5A, 1'b1, 1'b0, 1'b0, 1'b1);
        handshake();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
